// File: rtl/mips_isa_pkg.sv
// MIPS-I ISA constants, decode-flag bundle and instruction field helpers
// shared by the ID-stage decoder and register file.
package mips_isa_pkg;

    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int RADDR_W = 5;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LWL    = 6'h22;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_LWR    = 6'h26;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SWL    = 6'h2A;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_SWR    = 6'h2E;
    localparam logic [5:0] OP_LL     = 6'h30;
    localparam logic [5:0] OP_SC     = 6'h38;

    // R-type function codes that change the default R-type decode
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    // REGIMM rt codes that link
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic link;
        logic reg_dst;
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic reg_write;
        logic jump_register;
        logic sign_or_zero;
        logic syscall;
    } ctrl_t;

    function automatic logic [5:0] f_op(input logic [31:0] ins);
        return ins[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ins);
        return ins[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ins);
        return ins[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ins);
        return ins[15:11];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] ins);
        return ins[5:0];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] ins);
        return ins[15:0];
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: three combinational read ports, one write port,
// r0 hardwired to zero, asynchronous active-low clear.
module mips_regfile
    import mips_isa_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [RADDR_W-1:0] i_ra0,
    input  logic [RADDR_W-1:0] i_ra1,
    input  logic [RADDR_W-1:0] i_ra2,
    input  logic [RADDR_W-1:0] i_wa,
    input  logic [XLEN-1:0]    i_wd,
    input  logic               i_we,
    output logic [XLEN-1:0]    o_rd0,
    output logic [XLEN-1:0]    o_rd1,
    output logic [XLEN-1:0]    o_rd2
);

    logic [NREGS-1:0][XLEN-1:0] r_regs;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_regs <= '0;
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Reads come from stored state only; a same-cycle write is not bypassed.
    assign o_rd0 = (i_ra0 == '0) ? '0 : r_regs[i_ra0];
    assign o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/mips_id_core.sv
// ID-stage block: MIPS-I control decode, jump/branch target calculation
// and the architectural register file with its writeback port.
module mips_id_core
    import mips_isa_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] jr_value,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    output logic        link,
    output logic        reg_dst,
    output logic        jump,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic        jump_register,
    output logic        sign_or_zero,
    output logic        syscall,
    output logic [5:0]  alu_control,
    output logic [4:0]  dest_reg,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] dest_data,
    output logic [31:0] next_addr
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [31:0] w_br_off;
    ctrl_t       w_ctrl;

    assign w_op    = f_op(instr);
    assign w_funct = f_funct(instr);
    assign w_rs    = f_rs(instr);
    assign w_rt    = f_rt(instr);
    assign w_rd    = f_rd(instr);
    assign w_imm   = f_imm(instr);

    assign alu_control = (w_op == OP_RTYPE) ? w_funct : w_op;

    always_comb begin
        w_ctrl = '0;
        case (w_op)
            OP_RTYPE: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                case (w_funct)
                    FN_JR: begin
                        w_ctrl.jump          = 1'b1;
                        w_ctrl.jump_register = 1'b1;
                        w_ctrl.reg_write     = 1'b0;
                    end
                    FN_JALR: begin
                        w_ctrl.jump          = 1'b1;
                        w_ctrl.jump_register = 1'b1;
                        w_ctrl.link          = 1'b1;
                    end
                    FN_SYSCALL: begin
                        w_ctrl.syscall   = 1'b1;
                        w_ctrl.reg_write = 1'b0;
                    end
                    // Results of these land in HI/LO, not the GPR file
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO:
                        w_ctrl.reg_write = 1'b0;
                    default: ;
                endcase
            end
            OP_J: begin
                w_ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.jump      = 1'b1;
                w_ctrl.link      = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                w_ctrl.branch       = 1'b1;
                w_ctrl.sign_or_zero = 1'b1;
            end
            OP_REGIMM: begin
                if (w_rt == RT_BLTZAL || w_rt == RT_BGEZAL) begin
                    w_ctrl.branch       = 1'b1;
                    w_ctrl.sign_or_zero = 1'b1;
                    w_ctrl.link         = 1'b1;
                    w_ctrl.reg_write    = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                w_ctrl.alu_src      = 1'b1;
                w_ctrl.reg_write    = 1'b1;
                w_ctrl.sign_or_zero = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_LL: begin
                w_ctrl.mem_read     = 1'b1;
                w_ctrl.alu_src      = 1'b1;
                w_ctrl.reg_write    = 1'b1;
                w_ctrl.sign_or_zero = 1'b1;
                w_ctrl.syscall      = (w_op == OP_LL);
            end
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_SC: begin
                w_ctrl.mem_write    = 1'b1;
                w_ctrl.alu_src      = 1'b1;
                w_ctrl.sign_or_zero = 1'b1;
                // SC writes its success flag back to rt and traps to the monitor
                w_ctrl.reg_write    = (w_op == OP_SC);
                w_ctrl.syscall      = (w_op == OP_SC);
            end
            default: ;
        endcase
    end

    assign link          = w_ctrl.link;
    assign reg_dst       = w_ctrl.reg_dst;
    assign jump          = w_ctrl.jump;
    assign branch        = w_ctrl.branch;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign alu_src       = w_ctrl.alu_src;
    assign reg_write     = w_ctrl.reg_write;
    assign jump_register = w_ctrl.jump_register;
    assign sign_or_zero  = w_ctrl.sign_or_zero;
    assign syscall       = w_ctrl.syscall;

    assign dest_reg = w_ctrl.reg_dst ? w_rd : (w_ctrl.link ? REG_RA : w_rt);

    assign w_br_off = {{14{w_imm[15]}}, w_imm, 2'b00};

    always_comb begin
        next_addr = pc_plus4 + w_br_off;
        if (w_ctrl.jump_register) begin
            next_addr = jr_value;
        end else if (w_ctrl.jump) begin
            next_addr = {pc_plus4[31:28], instr[25:0], 2'b00};
        end
    end

    mips_regfile u_regfile (
        .CLK   (CLK),
        .RESET (RESET),
        .i_ra0 (w_rs),
        .i_ra1 (w_rt),
        .i_ra2 (dest_reg),
        .i_wa  (wr_addr),
        .i_wd  (wr_data),
        .i_we  (wr_en),
        .o_rd0 (rs_data),
        .o_rd1 (rt_data),
        .o_rd2 (dest_data)
    );

endmodule

// File: tb/tb_mips_id_core.sv
// Directed-vector bench for mips_id_core: reset clear, writeback timing,
// r0 behaviour and decode/next-address for representative instructions.
module tb_mips_id_core;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] jr_value;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        link, reg_dst, jump, branch, mem_read, mem_write;
    logic        alu_src, reg_write, jump_register, sign_or_zero, syscall;
    logic [5:0]  alu_control;
    logic [4:0]  dest_reg;
    logic [31:0] rs_data, rt_data, dest_data, next_addr;

    int n_vec = 0;
    int n_err = 0;

    // {link, reg_dst, jump, branch, mem_read, mem_write, alu_src,
    //  reg_write, jump_register, sign_or_zero, syscall}
    logic [10:0] flags;
    assign flags = {link, reg_dst, jump, branch, mem_read, mem_write, alu_src,
                    reg_write, jump_register, sign_or_zero, syscall};

    always #5 CLK = ~CLK;

    mips_id_core dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .instr         (instr),
        .pc_plus4      (pc_plus4),
        .jr_value      (jr_value),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .link          (link),
        .reg_dst       (reg_dst),
        .jump          (jump),
        .branch        (branch),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .alu_src       (alu_src),
        .reg_write     (reg_write),
        .jump_register (jump_register),
        .sign_or_zero  (sign_or_zero),
        .syscall       (syscall),
        .alu_control   (alu_control),
        .dest_reg      (dest_reg),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .dest_data     (dest_data),
        .next_addr     (next_addr)
    );

    task automatic test_reset;
        logic [4:0] a;
        // Fill r1..r31 with nonzero data, then drop reset mid-cycle.
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA000_0000 + 32'(i);
            @(negedge CLK);
        end
        wr_en = 1'b0;
        instr = {6'h00, 5'd3, 5'd3, 5'd3, 5'd0, 6'h21};
        #1;
        n_vec++;
        if (rs_data !== 32'hA000_0003) begin
            n_err++;
            $display("FAIL prefill_r3: got %08h want %08h", rs_data, 32'hA000_0003);
        end
        #2 RESET = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            instr = {6'h00, a, a, a, 5'd0, 6'h21};
            #0.1;
            n_vec++;
            if (rs_data !== 32'h0 || rt_data !== 32'h0 || dest_data !== 32'h0) begin
                n_err++;
                $display("FAIL reset_clear r%0d: got rs=%08h rt=%08h dst=%08h want 0",
                         i, rs_data, rt_data, dest_data);
            end
        end
        // Write attempted while reset is held must be lost.
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7777_7777;
        @(negedge CLK);
        wr_en = 1'b0;
        RESET = 1'b1;
        instr = {6'h00, 5'd7, 5'd0, 5'd0, 5'd0, 6'h21};
        #1;
        n_vec++;
        if (rs_data !== 32'h0) begin
            n_err++;
            $display("FAIL write_in_reset: got %08h want 00000000", rs_data);
        end
    endtask

    task automatic test_writeback;
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        instr = 32'h00A0_0000;
        #1;
        n_vec++;
        if (rs_data !== 32'h0) begin
            n_err++;
            $display("FAIL wb_before_edge: got %08h want 00000000", rs_data);
        end
        @(posedge CLK); #1;
        n_vec++;
        if (rs_data !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL wb_after_edge: got %08h want deadbeef", rs_data);
        end
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic test_r0;
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
        instr = 32'h0000_0000;
        @(negedge CLK);
        wr_en = 1'b0;
        #1;
        n_vec++;
        if (rs_data !== 32'h0) begin
            n_err++;
            $display("FAIL r0_write: got %08h want 00000000", rs_data);
        end
    endtask

    task automatic test_addu;
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4444_0004;
        @(negedge CLK);
        wr_addr = 5'd6; wr_data = 32'h6666_0006;
        @(negedge CLK);
        wr_en = 1'b0;
        instr = 32'h00A6_2021;
        #1;
        n_vec++;
        if (flags !== 11'b01000001000 || dest_reg !== 5'd4 || alu_control !== 6'h21) begin
            n_err++;
            $display("FAIL addu_decode: got flags=%b dst=%0d alu=%h want 01000001000 4 21",
                     flags, dest_reg, alu_control);
        end
        n_vec++;
        if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'h6666_0006 || dest_data !== 32'h4444_0004) begin
            n_err++;
            $display("FAIL addu_reads: got rs=%08h rt=%08h dst=%08h want deadbeef 66660006 44440004",
                     rs_data, rt_data, dest_data);
        end
    endtask

    task automatic test_jal;
        instr = 32'h0C10_0000; pc_plus4 = 32'h4000_0004;
        #1;
        n_vec++;
        if (next_addr !== 32'h4040_0000 || flags !== 11'b10100001000 || dest_reg !== 5'd31) begin
            n_err++;
            $display("FAIL jal: got na=%08h flags=%b dst=%0d want 40400000 10100001000 31",
                     next_addr, flags, dest_reg);
        end
    endtask

    task automatic test_jr;
        instr = 32'h03E0_0008; jr_value = 32'h0040_0020; pc_plus4 = 32'h1000_0000;
        #1;
        n_vec++;
        if (next_addr !== 32'h0040_0020 || flags !== 11'b01100000100) begin
            n_err++;
            $display("FAIL jr: got na=%08h flags=%b want 00400020 01100000100", next_addr, flags);
        end
    endtask

    task automatic test_branch;
        instr = 32'h1000_FFFF; pc_plus4 = 32'h0000_0100;
        #1;
        n_vec++;
        if (next_addr !== 32'h0000_00FC || flags !== 11'b00010000010) begin
            n_err++;
            $display("FAIL beq_back: got na=%08h flags=%b want 000000fc 00010000010", next_addr, flags);
        end
        // BLTZAL +3 words: links to r31
        instr = 32'h0410_0003; pc_plus4 = 32'h0000_2000;
        #1;
        n_vec++;
        if (next_addr !== 32'h0000_200C || flags !== 11'b10010001010 || dest_reg !== 5'd31) begin
            n_err++;
            $display("FAIL bltzal: got na=%08h flags=%b dst=%0d want 0000200c 10010001010 31",
                     next_addr, flags, dest_reg);
        end
        // Wraparound of the branch target across 2^32
        instr = 32'h1400_0001; pc_plus4 = 32'hFFFF_FFFC;
        #1;
        n_vec++;
        if (next_addr !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL bne_wrap: got na=%08h want 00000000", next_addr);
        end
    endtask

    task automatic test_itype;
        instr = 32'h30A7_00FF;
        #1;
        n_vec++;
        if (flags !== 11'b00000011000 || dest_reg !== 5'd7 || alu_control !== 6'h0C) begin
            n_err++;
            $display("FAIL andi: got flags=%b dst=%0d alu=%h want 00000011000 7 0c",
                     flags, dest_reg, alu_control);
        end
        instr = 32'h8CA9_0004;
        #1;
        n_vec++;
        if (flags !== 11'b00001011010 || dest_reg !== 5'd9) begin
            n_err++;
            $display("FAIL lw: got flags=%b dst=%0d want 00001011010 9", flags, dest_reg);
        end
        instr = 32'hE0A8_0000;
        #1;
        n_vec++;
        if (flags !== 11'b00000111011 || dest_reg !== 5'd8) begin
            n_err++;
            $display("FAIL sc: got flags=%b dst=%0d want 00000111011 8", flags, dest_reg);
        end
        instr = 32'hFC00_0000;
        #1;
        n_vec++;
        if (flags !== 11'b00000000000) begin
            n_err++;
            $display("FAIL unknown_op: got flags=%b want 00000000000", flags);
        end
    endtask

    task automatic test_rtype_special;
        instr = 32'h0000_000C;
        #1;
        n_vec++;
        if (flags !== 11'b01000000001) begin
            n_err++;
            $display("FAIL syscall: got flags=%b want 01000000001", flags);
        end
        instr = 32'h00A6_0018;
        #1;
        n_vec++;
        if (flags !== 11'b01000000000 || alu_control !== 6'h18) begin
            n_err++;
            $display("FAIL mult: got flags=%b alu=%h want 01000000000 18", flags, alu_control);
        end
        instr = 32'h00A0_F809; jr_value = 32'h0000_0400;
        #1;
        n_vec++;
        if (flags !== 11'b11100001100 || dest_reg !== 5'd31 || next_addr !== 32'h0000_0400) begin
            n_err++;
            $display("FAIL jalr: got flags=%b dst=%0d na=%08h want 11100001100 31 00000400",
                     flags, dest_reg, next_addr);
        end
    endtask

    initial begin
        RESET = 1'b0; instr = '0; pc_plus4 = '0; jr_value = '0;
        wr_addr = '0; wr_data = '0; wr_en = 1'b0;
        #12;
        test_reset;
        test_writeback;
        test_r0;
        test_addu;
        test_jal;
        test_jr;
        test_branch;
        test_itype;
        test_rtype_special;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
